// File: rtl/seq_pkg.sv
// seq_pkg
//   Shared definitions for the sequence-controller phase bus and its
//   responder: phase encodings, responder state enum, err_code values and a
//   helper that returns the legal successor of a phase.
package seq_pkg;

  // Phase codes driven by the sequence controller on its q bus.
  typedef enum logic [1:0] {
    START0 = 2'b00,
    START1 = 2'b01,
    START2 = 2'b10,
    FINISH = 2'b11
  } phase_t;

  // Responder states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_TRACK = 2'b01,
    ST_ERR   = 2'b10,
    ST_SYNC  = 2'b11
  } resp_state_t;

  // err_code values.
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_DWELL   = 2'b10;

  // The phase cycle is a plain modulo-4 increment, so the legal successor
  // is prev + 1 (FINISH wraps back to START0).
  function automatic phase_t next_phase(input phase_t p);
    return phase_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/seq_phase_legal.sv
// seq_phase_legal
//   Combinational legality check of one (prev, cur) phase pair.
//   Ports:
//     prev        in  2  phase sampled on the previous edge
//     cur         in  2  phase sampled on this edge
//     legal       out 1  pair is an allowed transition or a repeat
//     same_phase  out 1  cur equals prev (a repeat, which feeds the dwell count)
import seq_pkg::*;

module seq_phase_legal (
  input  phase_t prev,
  input  phase_t cur,
  output logic   legal,
  output logic   same_phase
);

  // Repeats are always legal here (00 idles, non-zero repeats are policed by
  // the dwell counter in the responder); otherwise only the successor phase.
  assign same_phase = (cur == prev);
  assign legal      = same_phase || (cur == next_phase(prev));

endmodule

// File: rtl/seq_phase_responder.sv
// seq_phase_responder
//   Consumer side of the sequence controller's 2-bit phase bus. Samples the
//   phase every clock, checks that only start0->start1->start2->finish->start0
//   transitions occur, acknowledges each completed sequence with a one-cycle
//   done pulse and counts it. Violations either latch a sticky error (strict)
//   or resynchronise quietly with a resync pulse (lenient).
//
//   Optional feature macro: SEQ_PHASE_RESP_DWELL_EN
//     defined   -> dwell counter built in; a non-start0 phase held for more
//                  than MAX_DWELL consecutive samples is a violation (err_code 10)
//     undefined -> repeated non-zero phases are legal indefinitely
//
//   Parameters:
//     CNT_W      width of the completed-sequence counter
//     MAX_DWELL  max consecutive samples of one non-start0 phase
//   Ports:
//     clk       in  1      rising-edge clock
//     rst_n     in  1      synchronous active-low reset
//     phase_in  in  2      controller phase code
//     mode      in  1      1 strict, 0 lenient
//     clr_err   in  1      clears sticky error while in ERR
//     busy      out 1      high while tracking a sequence
//     done      out 1      one-cycle pulse per completed sequence
//     resync    out 1      one-cycle pulse on a lenient-mode violation
//     err       out 1      sticky error flag
//     err_code  out 2      01 illegal transition, 10 dwell timeout
//     seq_cnt   out CNT_W  completed sequences, wrapping
import seq_pkg::*;

module seq_phase_responder #(
  parameter int CNT_W     = 8,
  parameter int MAX_DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       phase_in,
  input  logic             mode,
  input  logic             clr_err,
  output logic             busy,
  output logic             done,
  output logic             resync,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] seq_cnt
);

  // Elaboration-time parameter guards.
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("seq_phase_responder: CNT_W must be >= 1");
  end
  if (MAX_DWELL < 1) begin : g_bad_max_dwell
    $error("seq_phase_responder: MAX_DWELL must be >= 1");
  end

  resp_state_t      state_reg, state_next;
  phase_t           prev_phase_reg;
  phase_t           cur_phase;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             resync_reg, resync_next;
  logic             err_reg, err_next;
  logic [1:0]       err_code_reg, err_code_next;
  logic [CNT_W-1:0] seq_cnt_reg, seq_cnt_next;

  logic             legal;
  logic             same_phase;
  logic             timeout;

  assign cur_phase = phase_t'(phase_in);

  seq_phase_legal u_legal (
    .prev       (prev_phase_reg),
    .cur        (cur_phase),
    .legal      (legal),
    .same_phase (same_phase)
  );

`ifdef SEQ_PHASE_RESP_DWELL_EN
  // Counts consecutive samples of the current phase. It saturates one above
  // MAX_DWELL so it cannot wrap back into the legal range while a phase
  // stays stuck in states that do not check it.
  localparam int DW = $clog2(MAX_DWELL + 2);

  logic [DW-1:0] dwell_reg, dwell_next;

  always_comb begin
    dwell_next = dwell_reg;
    if (!same_phase) begin
      dwell_next = DW'(1);
    end else if (dwell_reg != DW'(MAX_DWELL + 1)) begin
      dwell_next = dwell_reg + DW'(1);
    end
  end

  // This sample would take the run length past MAX_DWELL.
  assign timeout = same_phase && (cur_phase != START0) &&
                   (dwell_reg >= DW'(MAX_DWELL));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dwell_reg <= '0;
    end else begin
      dwell_reg <= dwell_next;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    done_next     = 1'b0;
    resync_next   = 1'b0;
    err_next      = err_reg;
    err_code_next = err_code_reg;
    seq_cnt_next  = seq_cnt_reg;

    case (state_reg)
      ST_IDLE, ST_TRACK: begin
        if (!legal || timeout) begin
          if (mode) begin
            state_next    = ST_ERR;
            err_next      = 1'b1;
            // An illegal pair outranks a timeout seen on the same edge.
            err_code_next = !legal ? ERR_ILLEGAL : ERR_DWELL;
          end else begin
            state_next  = ST_SYNC;
            resync_next = 1'b1;
          end
        end else if (state_reg == ST_IDLE) begin
          if (cur_phase == START1) begin
            state_next = ST_TRACK;
          end
        end else if (prev_phase_reg == FINISH && cur_phase == START0) begin
          state_next   = ST_IDLE;
          done_next    = 1'b1;
          seq_cnt_next = seq_cnt_reg + CNT_W'(1);
        end
      end
      ST_ERR: begin
        if (clr_err) begin
          state_next    = ST_SYNC;
          err_next      = 1'b0;
          err_code_next = ERR_NONE;
        end
      end
      ST_SYNC: begin
        if (cur_phase == START0) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    busy_next = (state_next == ST_TRACK);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      prev_phase_reg <= START0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      resync_reg     <= 1'b0;
      err_reg        <= 1'b0;
      err_code_reg   <= ERR_NONE;
      seq_cnt_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      prev_phase_reg <= cur_phase;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      resync_reg     <= resync_next;
      err_reg        <= err_next;
      err_code_reg   <= err_code_next;
      seq_cnt_reg    <= seq_cnt_next;
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign resync   = resync_reg;
  assign err      = err_reg;
  assign err_code = err_code_reg;
  assign seq_cnt  = seq_cnt_reg;

endmodule

// File: tb/tb_seq_phase_responder.sv
// tb_seq_phase_responder
//   Directed bench for seq_phase_responder (CNT_W=2, MAX_DWELL=4).
//   Honours SEQ_PHASE_RESP_DWELL_EN for the dwell-timeout expectations.
module tb_seq_phase_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] phase_in;
  logic       mode;
  logic       clr_err;
  logic       busy;
  logic       done;
  logic       resync;
  logic       err;
  logic [1:0] err_code;
  logic [1:0] seq_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_phase_responder #(
    .CNT_W     (2),
    .MAX_DWELL (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .phase_in (phase_in),
    .mode     (mode),
    .clr_err  (clr_err),
    .busy     (busy),
    .done     (done),
    .resync   (resync),
    .err      (err),
    .err_code (err_code),
    .seq_cnt  (seq_cnt)
  );

  // Drive one phase sample, clock it in, look at outputs 1 time unit later.
  task automatic step(input logic [1:0] ph);
    phase_in = ph;
    @(posedge clk);
    #1;
    $display("t=%0t rst_n=%0b mode=%0b clr=%0b phase=%0d | busy=%0b done=%0b resync=%0b err=%0b code=%0d cnt=%0d",
             $time, rst_n, mode, clr_err, ph, busy, done, resync, err, err_code, seq_cnt);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic       done_seen;
  logic       busy_seen;
  logic [1:0] exp_wrap [4];

  initial begin
    exp_wrap[0] = 2'd1;
    exp_wrap[1] = 2'd2;
    exp_wrap[2] = 2'd3;
    exp_wrap[3] = 2'd0;

    rst_n    = 1'b0;
    mode     = 1'b1;
    clr_err  = 1'b0;
    phase_in = 2'b00;

    // Reset state
    step(2'b00);
    step(2'b00);
    chk("rst_busy",   busy,     0);
    chk("rst_done",   done,     0);
    chk("rst_resync", resync,   0);
    chk("rst_err",    err,      0);
    chk("rst_code",   err_code, 0);
    chk("rst_cnt",    seq_cnt,  0);
    rst_n = 1'b1;

    // Basic sequence 00,01,10,11,00
    step(2'b00); chk("idle_busy", busy, 0);
    step(2'b01); chk("trk_busy1", busy, 1);
    step(2'b10); chk("trk_busy2", busy, 1);
    step(2'b11); chk("trk_busy3", busy, 1);
    chk("pre_done", done, 0);
    step(2'b00);
    chk("done1",      done,    1);
    chk("done1_busy", busy,    0);
    chk("done1_cnt",  seq_cnt, 1);
    step(2'b00);
    chk("done_pulse", done, 0);

    // Strict illegal 01 -> 11
    step(2'b01);
    step(2'b11);
    chk("strict_err",  err,      1);
    chk("strict_code", err_code, 1);
    chk("strict_busy", busy,     0);

    // ERR ignores valid traffic for 300 cycles
    done_seen = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 75; i++) begin
      step(2'b01); done_seen |= done; busy_seen |= busy;
      step(2'b10); done_seen |= done; busy_seen |= busy;
      step(2'b11); done_seen |= done; busy_seen |= busy;
      step(2'b00); done_seen |= done; busy_seen |= busy;
    end
    chk("err_no_done",  done_seen, 0);
    chk("err_no_busy",  busy_seen, 0);
    chk("err_cnt_hold", seq_cnt,   1);
    chk("err_sticky",   err,       1);

    // Clear, then SYNC waits for 00
    clr_err = 1'b1;
    step(2'b11);
    clr_err = 1'b0;
    chk("clr_err",  err,      0);
    chk("clr_code", err_code, 0);
    step(2'b01); chk("sync_wait_busy", busy, 0);
    step(2'b00); chk("sync_idle_busy", busy, 0);
    step(2'b01); chk("post_clr_busy",  busy, 1);
    step(2'b10);
    step(2'b11);
    step(2'b00);
    chk("post_clr_done", done,    1);
    chk("post_clr_cnt",  seq_cnt, 2);

    // Lenient violation 01 -> 00
    mode = 1'b0;
    step(2'b01);
    step(2'b00);
    chk("len_resync", resync, 1);
    chk("len_err",    err,    0);
    chk("len_busy",   busy,   0);
    step(2'b00);
    chk("len_resync_pulse", resync, 0);
    step(2'b01);
    step(2'b10);
    step(2'b11);
    step(2'b00);
    chk("len_done", done,    1);
    chk("len_cnt",  seq_cnt, 3);

    // Dwell: 01 held for 5 samples, strict
    mode = 1'b1;
    step(2'b01);
    step(2'b01);
    step(2'b01);
    step(2'b01);
    chk("dwell4_err",  err,  0);
    chk("dwell4_busy", busy, 1);
    step(2'b01);
`ifdef SEQ_PHASE_RESP_DWELL_EN
    chk("dwell5_err",  err,      1);
    chk("dwell5_code", err_code, 2);
    chk("dwell5_busy", busy,     0);
`else
    chk("dwell5_err",  err,      0);
    chk("dwell5_code", err_code, 0);
    chk("dwell5_busy", busy,     1);
`endif

    // Reset clears everything (including ERR)
    rst_n = 1'b0;
    step(2'b10);
    chk("rst2_err",  err,      0);
    chk("rst2_code", err_code, 0);
    chk("rst2_cnt",  seq_cnt,  0);
    rst_n = 1'b1;

    // Reset mid-sequence during start2
    step(2'b00);
    step(2'b01);
    step(2'b10);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    step(2'b11);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_cnt",  seq_cnt, 0);
    rst_n = 1'b1;
    step(2'b00);
    step(2'b01);
    step(2'b10);
    step(2'b11);
    step(2'b00);
    chk("mid_after_done", done,    1);
    chk("mid_after_cnt",  seq_cnt, 1);

    // Back-to-back sequences with CNT_W=2: 1,2,3,0
    rst_n = 1'b0;
    step(2'b00);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(2'b01);
      step(2'b10);
      step(2'b11);
      step(2'b00);
      chk($sformatf("wrap_done%0d", i), done,    1);
      chk($sformatf("wrap_cnt%0d", i),  seq_cnt, exp_wrap[i]);
    end

    // First sample after reset checked against 00: 10 is illegal
    rst_n = 1'b0;
    step(2'b00);
    rst_n = 1'b1;
    step(2'b10);
    chk("first_err",  err,      1);
    chk("first_code", err_code, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_phase_responder.md
# seq_phase_responder

Receiving end of the 2-bit sequence-controller phase bus. It samples the controller's phase code every clock and checks that only legal transitions occur: start0→start1→start2→finish→start0, with start0 allowed to idle. For each correctly completed sequence it returns a one-cycle `done` acknowledge and counts it. Illegal or stuck phases are flagged (strict mode) or silently resynchronised (lenient mode). It sits beside the sequence controller's state register, on the consumer side of its `q` bus.

## Interface
- `CNT_W`, default 8: width of the completed-sequence counter.
- `MAX_DWELL`, default 4: maximum consecutive cycles a non-start0 phase may persist.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `phase_in`  in  2  controller phase: 00 start0, 01 start1, 10 start2, 11 finish.
- `mode`  in  1  1 = strict (violations raise `err`), 0 = lenient (violations resync quietly).
- `clr_err`  in  1  clears sticky error; level, sampled each edge.
- `busy`  out  1  high while in TRACK.
- `done`  out  1  one-cycle pulse per legal completed sequence.
- `resync`  out  1  one-cycle pulse on lenient-mode violation.
- `err`  out  1  sticky error flag.
- `err_code`  out  2  01 illegal transition, 10 dwell timeout, 00 none.
- `seq_cnt`  out  CNT_W  completed sequences, wraps to 0.

## Operation
- Registers: `prev_phase` (reset 00), `dwell` counter, `state`.
- States: IDLE, TRACK, ERR, SYNC.
- Legal pairs (prev→cur):
  - 00→00, 00→01, 01→10, 10→11, 11→00.
  - Same non-zero phase repeated; this increments `dwell`.
  - Any change of phase reloads `dwell` to 1.
- IDLE: 00→01 moves to TRACK.
- TRACK:
  - 11→00 moves to IDLE, pulses `done`, and increments `seq_cnt`.
  - Any illegal pair is a violation.
  - `dwell` exceeding MAX_DWELL is a violation.
- Violation, strict (`mode`=1):
  - go to ERR.
  - `err`=1; `err_code` set (illegal transition has priority over timeout when both occur in the same cycle).
- Violation, lenient (`mode`=0): go to SYNC, pulse `resync`; `err` unchanged.
- ERR: ignores `phase_in`; `clr_err`=1 clears `err` and `err_code` and goes to SYNC.
- SYNC: waits for `phase_in`=00, then IDLE. No checks run in SYNC or ERR.
- `prev_phase` updates every cycle in all states.
- `seq_cnt` wraps from 2^CNT_W−1 to 0.
- `mode` is sampled per cycle; changing it mid-sequence affects only future violations.
- `clr_err` outside ERR has no effect.

## Timing
- All outputs are registered. A pair sampled at edge k is reflected on outputs after edge k.
- `done` latency: 1 edge after the 00 following finish is sampled; high for exactly one cycle.
- Minimum legal sequence: 4 edges, 01,10,11,00. Back-to-back sequences with no idle 00 between them are legal: 00 then 01 on the next edge.
- Reset values, with `rst_n` low at an edge:
  - state IDLE, `prev_phase`=00, `dwell`=0.
  - all outputs 0, `seq_cnt`=0.
- Reset mid-sequence abandons it with no `done`. After reset, the first pair is checked against `prev_phase`=00, so a first sample of 10 or 11 is a violation.

## Configuration
- `SEQ_PHASE_RESP_DWELL_EN` defined: the dwell counter and timeout check are built in; `err_code` 10 is reachable.
- Undefined: no dwell counter. Repeated non-zero phases are legal indefinitely and `err_code` is never 10.

## Structure
- Shared package `seq_pkg`:
  - phase encodings: START0, START1, START2, FINISH.
  - responder state enum.
  - `err_code` constants: ERR_NONE, ERR_ILLEGAL, ERR_DWELL.
- One sub-module, `seq_phase_legal`: combinational legality check of (prev, cur) → legal, same_phase.

## Test plan
- Reset, then phase 00,01,10,11,00 → `done`=1 one cycle after the final 00 is sampled; `seq_cnt`=1; `busy` high 3 cycles.
- Strict mode, phase 00,01,11 → `err`=1, `err_code`=01 after the 11 edge; 300 further cycles of valid sequences leave `seq_cnt` unchanged; `clr_err`, then 00 → IDLE.
- Lenient mode, phase 01,00 mid-sequence → `resync` pulses once, `err`=0; the next full sequence gives `done`.
- `SEQ_PHASE_RESP_DWELL_EN` defined, strict mode, phase 01 held 5 cycles with MAX_DWELL=4 → `err_code`=10; undefined → no error.
- CNT_W=2, 4 sequences back-to-back → `seq_cnt` reads 1,2,3,0.
- `rst_n` low during start2 → all outputs 0; then 00,01,10,11,00 → `done`, `seq_cnt`=1.
